fetch_stage: RTL and testbench

//  Instruction-fetch stage of the MIPS datapath, directly upstream of the Control unit.

---
 rtl/mips_pkg.sv | 16 +
 rtl/if_id_register.sv | 54 +++++
 rtl/fetch_stage.sv | 125 ++++++++++++
 tb/tb_fetch_stage.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS front end: reset vector, NOP encoding,
// opcode field bounds and the fetch FSM state encoding.
package mips_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: valid/instr/pc_plus4 with load and flush.
// Flush wins over load and inserts a bubble carrying NOP_INSTR.
module if_id_register
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    if (flush) begin
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      pc_plus4_d = 32'h0000_0000;
    end else if (load) begin
      valid_d    = 1'b1;
      instr_d    = instr_in;
      pc_plus4_d = pc_plus4_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0000_0000;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid    = valid_q;
  assign instr    = instr_q;
  assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, imem request, one-entry skid buffer
// and the FETCH/HOLD FSM feeding the IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic [5:0]  if_id_op,
  output logic        dbg_state
);

  // Handshake: a fetch completes in a cycle where imem_req && imem_ready; the
  // word on imem_rdata belongs to imem_addr. Address and request stay put while
  // ready is low unless a redirect arrives.

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         skid_valid_q, skid_valid_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic [31:0]  skid_pc4_q, skid_pc4_d;

  logic         ifid_load;
  logic         ifid_flush;
  logic [31:0]  ifid_instr_in;
  logic [31:0]  ifid_pc4_in;
  logic [31:0]  pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc4_d    = skid_pc4_q;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    ifid_instr_in = imem_rdata;
    ifid_pc4_in   = pc_plus4;

    if (redirect_valid) begin
      // Redirect beats stall and drops any word in flight or parked in the skid.
      pc_d         = redirect_pc & ~32'd3;
      ifid_flush   = 1'b1;
      skid_valid_d = 1'b0;
      state_d      = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready && !stall) begin
            ifid_load = 1'b1;
            pc_d      = pc_plus4;
          end else if (imem_ready && stall) begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_plus4;
            pc_d         = pc_plus4;
            state_d      = HOLD;
          end else if (!imem_ready && !stall) begin
            ifid_flush = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_load     = 1'b1;
            ifid_instr_in = skid_instr_q;
            ifid_pc4_in   = skid_pc4_q;
            skid_valid_d  = 1'b0;
            state_d       = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk         (clk),
    .reset       (reset),
    .load        (ifid_load),
    .flush       (ifid_flush),
    .instr_in    (ifid_instr_in),
    .pc_plus4_in (ifid_pc4_in),
    .valid       (if_id_valid),
    .instr       (if_id_instr),
    .pc_plus4    (if_id_pc_plus4)
  );

  assign imem_req  = reset && (state_q == FETCH);
  assign imem_addr = pc_q;
  assign if_id_op  = if_id_instr[OP_MSB:OP_LSB];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stall/skid, redirect,
// wait states, wrap-around and reset during HOLD.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic [5:0]  if_id_op;
  logic        dbg_state;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_op       (if_id_op),
    .dbg_state      (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(); step(); step();
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req actual=%0b expected=0", imem_req); end else passed++;
    checks++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL reset_valid actual=%0b expected=0", if_id_valid); end else passed++;
    checks++; if (if_id_instr !== 32'h0) begin fails++; $display("FAIL reset_instr actual=%h expected=00000000", if_id_instr); end else passed++;
    checks++; if (if_id_pc_plus4 !== 32'h0) begin fails++; $display("FAIL reset_pc4 actual=%h expected=00000000", if_id_pc_plus4); end else passed++;
    reset = 1'b1;
    #1;
    checks++; if (imem_addr !== 32'h0040_0000) begin fails++; $display("FAIL reset_addr actual=%h expected=00400000", imem_addr); end else passed++;
    checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL release_req actual=%0b expected=1", imem_req); end else passed++;
    step();
    checks++; if (if_id_pc_plus4 !== 32'h0040_0004) begin fails++; $display("FAIL first_pc4 actual=%h expected=00400004", if_id_pc_plus4); end else passed++;
  endtask

  task automatic test_stream();
    // First addi already in IF/ID from test_reset; check it and the next one.
    checks++; if (if_id_valid !== 1'b1 || if_id_op !== 6'h08) begin fails++; $display("FAIL stream_op0 actual=%0b/%h expected=1/08", if_id_valid, if_id_op); end else passed++;
    checks++; if (imem_addr !== 32'h0040_0004) begin fails++; $display("FAIL stream_addr0 actual=%h expected=00400004", imem_addr); end else passed++;
    step();
    checks++; if (if_id_pc_plus4 !== 32'h0040_0008 || if_id_instr !== 32'h2008_0005) begin fails++; $display("FAIL stream_ifid1 actual=%h/%h expected=00400008/20080005", if_id_pc_plus4, if_id_instr); end else passed++;
    checks++; if (imem_addr !== 32'h0040_0008) begin fails++; $display("FAIL stream_addr1 actual=%h expected=00400008", imem_addr); end else passed++;
  endtask

  task automatic test_stall();
    imem_rdata = 32'h8C09_0000; stall = 1'b1;
    step();
    checks++; if (if_id_instr !== 32'h2008_0005 || if_id_pc_plus4 !== 32'h0040_0008) begin fails++; $display("FAIL stall_hold actual=%h/%h expected=20080005/00400008", if_id_instr, if_id_pc_plus4); end else passed++;
    checks++; if (imem_req !== 1'b0 || dbg_state !== 1'b1) begin fails++; $display("FAIL stall_req actual=%0b/%0b expected=0/1", imem_req, dbg_state); end else passed++;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    checks++; if (if_id_instr !== 32'h2008_0005 || imem_addr !== 32'h0040_000C) begin fails++; $display("FAIL stall_hold2 actual=%h/%h expected=20080005/0040000c", if_id_instr, imem_addr); end else passed++;
    stall = 1'b0;
    step();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h8C09_0000 || if_id_pc_plus4 !== 32'h0040_000C) begin fails++; $display("FAIL skid_emit actual=%0b/%h/%h expected=1/8c090000/0040000c", if_id_valid, if_id_instr, if_id_pc_plus4); end else passed++;
    checks++; if (if_id_op !== 6'h23 || imem_addr !== 32'h0040_000C || imem_req !== 1'b1) begin fails++; $display("FAIL skid_next actual=%h/%h/%0b expected=23/0040000c/1", if_id_op, imem_addr, imem_req); end else passed++;
  endtask

  task automatic test_redirect_hold();
    imem_rdata = 32'hAC0A_0000; stall = 1'b1;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0103;
    step();
    checks++; if (imem_addr !== 32'h0040_0100 || imem_req !== 1'b1) begin fails++; $display("FAIL redir_addr actual=%h/%0b expected=00400100/1", imem_addr, imem_req); end else passed++;
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin fails++; $display("FAIL redir_flush actual=%0b/%h expected=0/00000000", if_id_valid, if_id_instr); end else passed++;
    redirect_valid = 1'b0; stall = 1'b0; imem_rdata = 32'h0800_0000;
    step();
    checks++; if (if_id_instr !== 32'h0800_0000 || if_id_pc_plus4 !== 32'h0040_0104) begin fails++; $display("FAIL redir_next actual=%h/%h expected=08000000/00400104", if_id_instr, if_id_pc_plus4); end else passed++;
  endtask

  task automatic test_wait_states();
    imem_ready = 1'b0; imem_rdata = 32'h2008_0005;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin fails++; $display("FAIL wait_bubble%0d actual=%0b/%h expected=0/00000000", i, if_id_valid, if_id_instr); end else passed++;
      checks++; if (imem_addr !== 32'h0040_0104 || imem_req !== 1'b1) begin fails++; $display("FAIL wait_addr%0d actual=%h/%0b expected=00400104/1", i, imem_addr, imem_req); end else passed++;
    end
    // ready low under stall: nothing may move
    stall = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h0040_0104 || dbg_state !== 1'b0 || if_id_valid !== 1'b0) begin fails++; $display("FAIL wait_stall actual=%h/%0b/%0b expected=00400104/0/0", imem_addr, dbg_state, if_id_valid); end else passed++;
    stall = 1'b0; imem_ready = 1'b1;
    step();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h0040_0108) begin fails++; $display("FAIL wait_resume actual=%0b/%h expected=1/00400108", if_id_valid, if_id_pc_plus4); end else passed++;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr actual=%h expected=fffffffc", imem_addr); end else passed++;
    step();
    checks++; if (if_id_pc_plus4 !== 32'h0 || if_id_valid !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_next actual=%h/%0b/%h expected=00000000/1/00000000", if_id_pc_plus4, if_id_valid, imem_addr); end else passed++;
  endtask

  task automatic test_reset_in_hold();
    stall = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    checks++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0) begin fails++; $display("FAIL rst_hold actual=%0b/%0b expected=0/0", imem_req, if_id_valid); end else passed++;
    reset = 1'b1; redirect_valid = 1'b0; stall = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h0040_0000 || imem_req !== 1'b1 || dbg_state !== 1'b0) begin fails++; $display("FAIL rst_hold_release actual=%h/%0b/%0b expected=00400000/1/0", imem_addr, imem_req, dbg_state); end else passed++;
    step();
    checks++; if (if_id_instr !== 32'h1234_5678 || if_id_pc_plus4 !== 32'h0040_0004) begin fails++; $display("FAIL rst_hold_fetch actual=%h/%h expected=12345678/00400004", if_id_instr, if_id_pc_plus4); end else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_hold();
    test_wait_states();
    test_wrap();
    test_reset_in_hold();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
